// File: rtl/lcd_text_pkg.sv
// Shared constants for the LCD text character buffer.
// Holds the screen geometry, control character codes, command encodings,
// controller state encodings, and two address helper functions used by
// both the display read path and the host write path.
package lcd_text_pkg;

    localparam int COLS       = 80;
    localparam int ROWS       = 30;
    localparam int CHAR_W     = 8;
    localparam int CHAR_H     = 16;
    localparam int LCD_WIDTH  = COLS * CHAR_W;
    localparam int LCD_HIGHT  = ROWS * CHAR_H;
    localparam int ADDR_W     = 12;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CH_LF      = 8'h0A;
    localparam logic [7:0] CH_CR      = 8'h0D;

    localparam logic [1:0] OP_CLEAR      = 2'b00;
    localparam logic [1:0] OP_SET_CURSOR = 2'b01;
    localparam logic [1:0] OP_HOME       = 2'b10;
    localparam logic [1:0] OP_RESERVED   = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE       = 2'b00;
    localparam state_t ST_CLEAR_ALL  = 2'b01;
    localparam state_t ST_CLEAR_LINE = 2'b10;

    // (a + b) mod ROWS for a, b < ROWS, kept entirely in 5 bits so no
    // intermediate carry bit is needed.
    function automatic logic [4:0] add_rows(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] room;
        room = 5'(ROWS) - b;
        return (a >= room) ? (a - room) : (a + b);
    endfunction

    // row*80 + col, with the multiply built from two shifts.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        logic [ADDR_W-1:0] r;
        r = {{(ADDR_W-5){1'b0}}, row};
        return (r << 6) + (r << 4) + {{(ADDR_W-7){1'b0}}, col};
    endfunction

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port and one registered read
// port on the same clock. Contents are not reset, so it maps onto a block
// RAM. A read and write of the same address in one cycle returns old data.
// Ports:
//   pixel_clk  clock
//   we         write enable
//   wr_addr    write address
//   wr_data    write data
//   rd_addr    read address (sampled every cycle)
//   rd_data    registered read data, one cycle after rd_addr
module text_ram #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              pixel_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge pixel_clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/text_char_buffer.sv
// 80x30 text character buffer feeding the font ROM.
// The display side turns (pixel_cnt, row_cnt) into a character code plus
// glyph row/column with a fixed 2-cycle latency. The host side writes
// characters at an auto-advancing cursor with CR/LF, wrap and hardware
// scroll, and issues clear / set-cursor / home commands.
// Ports:
//   pixel_clk, rst_n             clock, async active-low reset
//   pixel_cnt, row_cnt, blanking LCD timing position and blanking flag
//   char_code, glyph_row,
//   glyph_col, char_valid        display outputs, all aligned
//   wr_valid, wr_char, wr_ready  host character stream
//   cmd_valid, cmd_op, cmd_col,
//   cmd_row, cmd_ready           host command port
//   busy                         high while a clear is running
//   cursor_col, cursor_row       logical cursor position
module text_char_buffer
    import lcd_text_pkg::*;
(
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_cnt,
    input  logic [9:0] row_cnt,
    input  logic       blanking,
    output logic [7:0] char_code,
    output logic [3:0] glyph_row,
    output logic [2:0] glyph_col,
    output logic       char_valid,
    input  logic       wr_valid,
    input  logic [7:0] wr_char,
    output logic       wr_ready,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [6:0] cmd_col,
    input  logic [4:0] cmd_row,
    output logic       cmd_ready,
    output logic       busy,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);

    state_t            state;
    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W-1:0] fill_last;
    logic [4:0]        scroll_base;

    logic [ADDR_W-1:0] s1_addr;
    logic              s1_oob;
    logic [3:0]        s1_grow;
    logic [2:0]        s1_gcol;
    logic              s1_valid;
    logic              s2_oob;
    logic [7:0]        ram_q;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic              char_accept;
    logic              is_ctrl;
    logic              need_newline;

    // Stage 1: map the screen text row through scroll_base to a physical
    // row and form the RAM address. row_cnt[8:4] is only meaningful when
    // in range; out-of-range positions are flagged and forced blank later.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr  <= '0;
            s1_oob   <= 1'b1;
            s1_grow  <= '0;
            s1_gcol  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_addr  <= cell_addr(add_rows(row_cnt[8:4], scroll_base), pixel_cnt[9:3]);
            s1_oob   <= (row_cnt >= 10'(LCD_HIGHT)) || (pixel_cnt >= 10'(LCD_WIDTH));
            s1_grow  <= row_cnt[3:0];
            s1_gcol  <= pixel_cnt[2:0];
            s1_valid <= !blanking;
        end
    end

    // Stage 2 runs alongside the registered RAM read.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_oob     <= 1'b1;
            glyph_row  <= '0;
            glyph_col  <= '0;
            char_valid <= 1'b0;
        end else begin
            s2_oob     <= s1_oob;
            glyph_row  <= s1_grow;
            glyph_col  <= s1_gcol;
            char_valid <= s1_valid;
        end
    end

    assign char_code = s2_oob ? BLANK_CHAR : ram_q;

    assign cmd_ready    = (state == ST_IDLE);
    assign wr_ready     = (state == ST_IDLE) && !cmd_valid;
    assign busy         = (state != ST_IDLE);
    assign char_accept  = wr_valid && wr_ready;
    assign is_ctrl      = (wr_char == CH_CR) || (wr_char == CH_LF);
    assign need_newline = char_accept &&
                          ((wr_char == CH_LF) || (!is_ctrl && cursor_col == 7'(COLS-1)));

    // The single write port is owned by the clear sweep while busy, and by
    // accepted printable characters while idle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = fill_addr;
        ram_wdata = BLANK_CHAR;
        if (state == ST_CLEAR_ALL || state == ST_CLEAR_LINE) begin
            ram_we = 1'b1;
        end else if (char_accept && !is_ctrl) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(add_rows(cursor_row, scroll_base), cursor_col);
            ram_wdata = wr_char;
        end
    end

    // Both clear states share one sweep counter running fill_addr up to
    // fill_last. A scroll clears the old scroll_base row, which becomes
    // the new bottom line once scroll_base advances.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLEAR_ALL;
            fill_addr   <= '0;
            fill_last   <= ADDR_W'(COLS*ROWS-1);
            cursor_col  <= '0;
            cursor_row  <= '0;
            scroll_base <= '0;
        end else begin
            case (state)
                ST_CLEAR_ALL: begin
                    if (fill_addr == fill_last) begin
                        state       <= ST_IDLE;
                        cursor_col  <= '0;
                        cursor_row  <= '0;
                        scroll_base <= '0;
                    end else begin
                        fill_addr <= fill_addr + ADDR_W'(1);
                    end
                end
                ST_CLEAR_LINE: begin
                    if (fill_addr == fill_last) begin
                        state <= ST_IDLE;
                    end else begin
                        fill_addr <= fill_addr + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_CLEAR: begin
                                state     <= ST_CLEAR_ALL;
                                fill_addr <= '0;
                                fill_last <= ADDR_W'(COLS*ROWS-1);
                            end
                            OP_SET_CURSOR: begin
                                cursor_col <= (cmd_col > 7'(COLS-1)) ? 7'(COLS-1) : cmd_col;
                                cursor_row <= (cmd_row > 5'(ROWS-1)) ? 5'(ROWS-1) : cmd_row;
                            end
                            OP_HOME: begin
                                cursor_col <= '0;
                                cursor_row <= '0;
                            end
                            default: ;
                        endcase
                    end else if (wr_valid) begin
                        if (is_ctrl || cursor_col == 7'(COLS-1)) begin
                            cursor_col <= '0;
                        end else begin
                            cursor_col <= cursor_col + 7'd1;
                        end
                        if (need_newline) begin
                            if (cursor_row < 5'(ROWS-1)) begin
                                cursor_row <= cursor_row + 5'd1;
                            end else begin
                                scroll_base <= add_rows(scroll_base, 5'd1);
                                state       <= ST_CLEAR_LINE;
                                fill_addr   <= cell_addr(scroll_base, 7'd0);
                                fill_last   <= cell_addr(scroll_base, 7'(COLS-1));
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    text_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .pixel_clk (pixel_clk),
        .we        (ram_we),
        .wr_addr   (ram_waddr),
        .wr_data   (ram_wdata),
        .rd_addr   (s1_addr),
        .rd_data   (ram_q)
    );

endmodule

// File: tb/tb_text_char_buffer.sv
// Self-checking bench for text_char_buffer.
// The reference model keeps the visible screen as a 30x80 array of
// logical lines: scrolling shifts lines up and blanks the bottom, so the
// bench never needs to know about the hardware scroll pointer.
module tb_text_char_buffer;
    import lcd_text_pkg::*;

    logic       pixel_clk = 1'b0;
    logic       rst_n     = 1'b1;
    logic [9:0] pixel_cnt = '0;
    logic [9:0] row_cnt   = '0;
    logic       blanking  = 1'b1;
    logic [7:0] char_code;
    logic [3:0] glyph_row;
    logic [2:0] glyph_col;
    logic       char_valid;
    logic       wr_valid  = 1'b0;
    logic [7:0] wr_char   = '0;
    logic       wr_ready;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = '0;
    logic [6:0] cmd_col   = '0;
    logic [4:0] cmd_row   = '0;
    logic       cmd_ready;
    logic       busy;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0] scr [ROWS][COLS];
    int m_col = 0;
    int m_row = 0;

    typedef struct {
        logic [9:0] px;
        logic [9:0] row;
        logic       blank;
        logic [7:0] code;
        logic [3:0] grow;
        logic [2:0] gcol;
        logic       valid;
    } rd_vec_t;

    always #5 pixel_clk = ~pixel_clk;

    text_char_buffer dut (
        .pixel_clk  (pixel_clk),
        .rst_n      (rst_n),
        .pixel_cnt  (pixel_cnt),
        .row_cnt    (row_cnt),
        .blanking   (blanking),
        .char_code  (char_code),
        .glyph_row  (glyph_row),
        .glyph_col  (glyph_col),
        .char_valid (char_valid),
        .wr_valid   (wr_valid),
        .wr_char    (wr_char),
        .wr_ready   (wr_ready),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_col    (cmd_col),
        .cmd_row    (cmd_row),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    task automatic check_val(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_fails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = BLANK_CHAR;
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic void model_newline();
        if (m_row < ROWS-1) begin
            m_row++;
        end else begin
            for (int r = 0; r < ROWS-1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = BLANK_CHAR;
        end
    endfunction

    function automatic void model_put(input logic [7:0] ch);
        if (ch == CH_CR) begin
            m_col = 0;
        end else if (ch == CH_LF) begin
            m_col = 0;
            model_newline();
        end else begin
            scr[m_row][m_col] = ch;
            if (m_col == COLS-1) begin
                m_col = 0;
                model_newline();
            end else begin
                m_col++;
            end
        end
    endfunction

    function automatic void model_cmd(input logic [1:0] op, input logic [6:0] c, input logic [4:0] r);
        case (op)
            OP_CLEAR:      model_clear();
            OP_SET_CURSOR: begin
                m_col = (int'(c) > COLS-1) ? COLS-1 : int'(c);
                m_row = (int'(r) > ROWS-1) ? ROWS-1 : int'(r);
            end
            OP_HOME:       begin m_col = 0; m_row = 0; end
            default: ;
        endcase
    endfunction

    task automatic check_cursor(input string name);
        check_val({name, "_cursor_col"}, cursor_col, m_col);
        check_val({name, "_cursor_row"}, cursor_row, m_row);
    endtask

    // Call with busy already high, just after a clock edge.
    task automatic measure_busy(input int exp_len, input string name);
        int cnt;
        bit saw_ready;
        cnt = 0;
        saw_ready = 0;
        while (busy && cnt < 3000) begin
            @(posedge pixel_clk);
            #1;
            cnt++;
            if (busy && (wr_ready || cmd_ready)) saw_ready = 1;
        end
        check_val({name, "_busy_len"}, cnt, exp_len);
        check_val({name, "_ready_low"}, saw_ready, 0);
    endtask

    task automatic send_char(input logic [7:0] ch);
        int guard;
        guard = 0;
        @(negedge pixel_clk);
        wr_valid = 1'b1;
        wr_char  = ch;
        #1;
        while (!wr_ready && guard < 5000) begin
            @(negedge pixel_clk);
            #1;
            guard++;
        end
        if (!wr_ready) begin
            check_val("wr_ready_timeout", 0, 1);
            wr_valid = 1'b0;
            return;
        end
        @(posedge pixel_clk);
        #1;
        wr_valid = 1'b0;
        model_put(ch);
        check_cursor("char");
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] c, input logic [4:0] r);
        int guard;
        guard = 0;
        @(negedge pixel_clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_col   = c;
        cmd_row   = r;
        #1;
        while (!cmd_ready && guard < 5000) begin
            @(negedge pixel_clk);
            #1;
            guard++;
        end
        if (!cmd_ready) begin
            check_val("cmd_ready_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge pixel_clk);
        #1;
        cmd_valid = 1'b0;
        model_cmd(op, c, r);
        if (op != OP_CLEAR) check_cursor("cmd");
    endtask

    // Streams every cell through the read pipeline one per cycle with a
    // random pixel offset inside the glyph; output at a falling edge
    // belongs to the position driven two falling edges earlier.
    task automatic check_screen(input string tag);
        logic [7:0] q_code[$];
        logic [7:0] q_aux[$];
        logic [7:0] exp_code;
        logic [7:0] exp_aux;
        int gr;
        int gc;
        for (int i = 0; i < COLS*ROWS + 2; i++) begin
            @(negedge pixel_clk);
            if (i >= 2) begin
                exp_code = q_code.pop_front();
                exp_aux  = q_aux.pop_front();
                check_val($sformatf("%s_code_cell%0d", tag, i-2), char_code, exp_code);
                check_val($sformatf("%s_glyph_cell%0d", tag, i-2),
                          {char_valid, glyph_row, glyph_col}, exp_aux);
            end
            if (i < COLS*ROWS) begin
                gr = $urandom_range(0, CHAR_H-1);
                gc = $urandom_range(0, CHAR_W-1);
                row_cnt   = 10'((i / COLS) * CHAR_H + gr);
                pixel_cnt = 10'((i % COLS) * CHAR_W + gc);
                blanking  = 1'b0;
                q_code.push_back(scr[i / COLS][i % COLS]);
                q_aux.push_back({1'b1, 4'(gr), 3'(gc)});
            end
        end
        blanking = 1'b1;
    endtask

    task automatic apply_stimulus(input rd_vec_t v);
        @(negedge pixel_clk);
        pixel_cnt = v.px;
        row_cnt   = v.row;
        blanking  = v.blank;
        repeat (2) @(posedge pixel_clk);
        #1;
    endtask

    task automatic check_output(input rd_vec_t v, input int idx);
        check_val($sformatf("vec%0d_char_code", idx), char_code, v.code);
        check_val($sformatf("vec%0d_glyph_row", idx), glyph_row, v.grow);
        check_val($sformatf("vec%0d_glyph_col", idx), glyph_col, v.gcol);
        check_val($sformatf("vec%0d_char_valid", idx), char_valid, v.valid);
    endtask

    initial begin
        rd_vec_t vecs[11];
        int pick;

        // Expected display after clearing and writing "AB" at the home cell.
        vecs[0]  = '{10'd0,    10'd0,    1'b0, 8'h41, 4'd0,  3'd0, 1'b1};
        vecs[1]  = '{10'd8,    10'd0,    1'b0, 8'h42, 4'd0,  3'd0, 1'b1};
        vecs[2]  = '{10'd7,    10'd3,    1'b0, 8'h41, 4'd3,  3'd7, 1'b1};
        vecs[3]  = '{10'd13,   10'd5,    1'b0, 8'h42, 4'd5,  3'd5, 1'b1};
        vecs[4]  = '{10'd16,   10'd0,    1'b0, 8'h20, 4'd0,  3'd0, 1'b1};
        vecs[5]  = '{10'd0,    10'd16,   1'b0, 8'h20, 4'd0,  3'd0, 1'b1};
        vecs[6]  = '{10'd639,  10'd479,  1'b0, 8'h20, 4'd15, 3'd7, 1'b1};
        vecs[7]  = '{10'd640,  10'd10,   1'b1, 8'h20, 4'd10, 3'd0, 1'b0};
        vecs[8]  = '{10'd0,    10'd480,  1'b1, 8'h20, 4'd0,  3'd0, 1'b0};
        vecs[9]  = '{10'd1023, 10'd1023, 1'b1, 8'h20, 4'd15, 3'd7, 1'b0};
        vecs[10] = '{10'd9,    10'd2,    1'b1, 8'h42, 4'd2,  3'd1, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check_val("rst_char_code", char_code, 8'h20);
        check_val("rst_glyph_row", glyph_row, 0);
        check_val("rst_glyph_col", glyph_col, 0);
        check_val("rst_char_valid", char_valid, 0);
        check_val("rst_wr_ready", wr_ready, 0);
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_busy", busy, 1);
        check_val("rst_cursor_col", cursor_col, 0);
        check_val("rst_cursor_row", cursor_row, 0);

        @(negedge pixel_clk);
        rst_n = 1'b1;
        measure_busy(2400, "por_clear");
        model_clear();
        check_val("idle_wr_ready", wr_ready, 1);
        check_val("idle_cmd_ready", cmd_ready, 1);
        check_screen("por");

        send_char(8'h41);
        send_char(8'h42);
        check_val("ab_cursor_col", cursor_col, 2);
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i]);
            check_output(vecs[i], i);
        end

        // Clamped cursor, then a write at the last cell forces a scroll.
        send_cmd(OP_SET_CURSOR, 7'd100, 5'd31);
        check_val("clamp_col", cursor_col, 79);
        check_val("clamp_row", cursor_row, 29);
        send_char(8'h5A);
        measure_busy(80, "wrap_scroll");
        check_screen("wrap_scroll");

        // LF on the bottom row scrolls again.
        send_char(8'h48);
        send_char(8'h49);
        send_char(CH_LF);
        check_val("lf_cursor_col", cursor_col, 0);
        check_val("lf_cursor_row", cursor_row, 29);
        measure_busy(80, "lf_scroll");
        check_screen("lf_scroll");

        // Clear and a character in the same cycle: the command wins.
        @(negedge pixel_clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        wr_valid  = 1'b1;
        wr_char   = 8'h51;
        #1;
        check_val("prio_wr_ready", wr_ready, 0);
        check_val("prio_cmd_ready", cmd_ready, 1);
        @(posedge pixel_clk);
        #1;
        cmd_valid = 1'b0;
        model_cmd(OP_CLEAR, 7'd0, 5'd0);
        check_val("prio_busy", busy, 1);
        measure_busy(2400, "prio_clear");
        check_val("prio_wr_ready_after", wr_ready, 1);
        @(posedge pixel_clk);
        #1;
        wr_valid = 1'b0;
        model_put(8'h51);
        check_cursor("prio_char");
        check_screen("prio");

        // Random host traffic against the line model.
        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 99);
            if (pick < 70)      send_char(8'($urandom_range(0, 255)));
            else if (pick < 80) send_char(CH_CR);
            else if (pick < 92) send_char(CH_LF);
            else if (pick < 96) send_cmd(OP_SET_CURSOR, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)));
            else if (pick < 98) send_cmd(OP_HOME, 7'd0, 5'd0);
            else                send_cmd(OP_RESERVED, 7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)));
        end
        repeat (100) @(posedge pixel_clk);
        #1;
        check_val("random_idle", busy, 0);
        check_screen("random");

        // Reset in the middle of a line clear.
        send_cmd(OP_SET_CURSOR, 7'd79, 5'd29);
        send_char(8'h58);
        @(negedge pixel_clk);
        pixel_cnt = 10'(79*CHAR_W + 3);
        row_cnt   = 10'(28*CHAR_H + 5);
        blanking  = 1'b0;
        repeat (20) @(posedge pixel_clk);
        #1;
        check_val("pre_rst_busy", busy, 1);
        check_val("pre_rst_char_code", char_code, 8'h58);
        @(negedge pixel_clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_char_code", char_code, 8'h20);
        check_val("mid_rst_glyph_row", glyph_row, 0);
        check_val("mid_rst_glyph_col", glyph_col, 0);
        check_val("mid_rst_char_valid", char_valid, 0);
        check_val("mid_rst_wr_ready", wr_ready, 0);
        check_val("mid_rst_cursor_row", cursor_row, 0);
        @(negedge pixel_clk);
        rst_n = 1'b1;
        blanking = 1'b1;
        measure_busy(2400, "rst_clear");
        model_clear();
        check_screen("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
